inst_fetch_if: RTL and testbench

INST_FETCH_IF -- requirements
Module: inst_fetch_if

---
 rtl/inst_fetch_if.sv | 131 +++++++++++++
 tb/tb_inst_fetch_if.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction-fetch front end. Issues one request at a time on
//               a req/addr_ok/data_ok memory port, buffers the returned word
//               for IF/ID, stalls the PC until delivery, and discards returns
//               that belong to flushed or reset-abandoned fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_if #(
    parameter logic [31:0] BOOT_ADDR = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        stallreq_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        inst_adel_o
);

    typedef enum logic [1:0] {
        S_REQ       = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_HOLD      = 2'd2,
        S_DISCARD   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_pending;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_adel;

    logic        w_aligned;
    logic        w_accept;
    logic        w_unused_stall;

    // Only the decode-stage bit of the stall vector matters here.
    assign w_unused_stall = ^{stall[5:2], stall[0]};

    assign w_aligned = (pc_i[1:0] == 2'b00);

    // A new request is only issued once the memory owes us nothing, so a
    // stale return can never be mistaken for the answer to a fresh request.
    assign inst_req  = !rst && (r_state == S_REQ) && !r_pending && w_aligned;
    assign inst_addr = pc_i;
    assign w_accept  = inst_req && inst_addr_ok;

    // The PC may only advance on the delivery edge, i.e. while in HOLD.
    assign stallreq_o = (r_state != S_HOLD);

    assign inst_o       = r_inst;
    assign inst_pc_o    = r_pc;
    assign inst_valid_o = r_valid;
    assign inst_adel_o  = r_adel;

    // Outstanding-return tracker; deliberately not reset so that a return
    // owed across a reset is still absorbed instead of being taken as data.
    always_ff @(posedge clk) begin
        r_pending <= (r_pending && !inst_data_ok) || w_accept;
    end

    // Fetch state machine with registered instruction buffer outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_inst  <= 32'h0;
            r_pc    <= BOOT_ADDR;
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // A flushed request may still be accepted this cycle;
                    // the pending bit then holds REQ off until its return.
                    if (flush) begin
                        r_state <= S_REQ;
                    end else if (!r_pending) begin
                        if (!w_aligned) begin
                            r_state <= S_HOLD;
                            r_inst  <= 32'h0;
                            r_pc    <= pc_i;
                            r_adel  <= 1'b1;
                            r_valid <= 1'b1;
                        end else if (inst_addr_ok) begin
                            r_pc    <= pc_i;
                            r_state <= S_WAIT_DATA;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (flush) begin
                        r_state <= inst_data_ok ? S_REQ : S_DISCARD;
                    end else if (inst_data_ok) begin
                        r_inst  <= inst_rdata;
                        r_adel  <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (flush || !stall[1]) begin
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (inst_data_ok) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_if
// Description : Self-checking bench for inst_fetch_if. Table of per-cycle
//               input/expected-output records plus hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_if;

    localparam logic [31:0] C_BOOT = 32'hbfc00000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic [5:0]  stall;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        stallreq_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_adel_o;

    int n_checks = 0;
    int n_fails  = 0;

    inst_fetch_if #(.BOOT_ADDR(C_BOOT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .stall        (stall),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .stallreq_o   (stallreq_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .inst_adel_o  (inst_adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [5:0]  stall;
        logic        fl;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        e_req;
        logic        e_sreq;
        logic        e_val;
        logic        e_adel;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [31:0] pc, input logic [5:0] st,
                       input logic fl, input logic aok, input logic dok,
                       input logic [31:0] rd, input logic e_req, input logic e_sreq,
                       input logic e_val, input logic e_adel,
                       input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.rst = r; v.pc = pc; v.stall = st; v.fl = fl; v.aok = aok; v.dok = dok;
        v.rd = rd; v.e_req = e_req; v.e_sreq = e_sreq; v.e_val = e_val;
        v.e_adel = e_adel; v.e_inst = e_inst; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packed view of every observable output: req, stallreq, valid, adel, inst, pc.
    function automatic logic [67:0] outs();
        return {inst_req, stallreq_o, inst_valid_o, inst_adel_o, inst_o, inst_pc_o};
    endfunction

    function automatic logic [31:0] addr_when_req();
        return inst_req ? inst_addr : 32'h0;
    endfunction

    task automatic drive(input logic r, input logic [31:0] pc, input logic [5:0] st,
                         input logic fl, input logic aok, input logic dok,
                         input logic [31:0] rd);
        rst = r; pc_i = pc; stall = st; flush = fl;
        inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [67:0] exp;
        logic [31:0] data;
        logic [31:0] addr;
        int          got;

        drive(1'b1, C_BOOT, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // rst pc stall fl aok dok rdata | req sreq val adel inst pc
        add(1, C_BOOT,       6'd0, 0,0,0,32'h0,        0,1,0,0, 32'h0,        C_BOOT);
        add(0, C_BOOT,       6'd0, 0,1,0,32'h0,        1,1,0,0, 32'h0,        C_BOOT);
        add(0, C_BOOT,       6'd0, 0,0,0,32'h0,        0,1,0,0, 32'h0,        C_BOOT);
        add(0, C_BOOT,       6'd0, 0,0,1,32'h3c080001, 0,1,0,0, 32'h0,        C_BOOT);
        add(0, C_BOOT,   6'b111101,0,0,0,32'h0,        0,0,1,0, 32'h3c080001, C_BOOT);
        add(0, 32'hbfc00004, 6'd0, 0,1,0,32'h0,        1,1,0,0, 32'h3c080001, C_BOOT);
        add(0, 32'hbfc00004, 6'd0, 0,0,1,32'h24090002, 0,1,0,0, 32'h3c080001, 32'hbfc00004);
        for (int i = 0; i < 4; i++)
            add(0, 32'hbfc00004, 6'b000010, 0,0,0,32'h0, 0,0,1,0, 32'h24090002, 32'hbfc00004);
        add(0, 32'hbfc00004, 6'd0, 0,0,0,32'h0,        0,0,1,0, 32'h24090002, 32'hbfc00004);
        for (int i = 0; i < 5; i++)
            add(0, 32'hbfc00008, 6'd0, 0,0,0,32'h0,    1,1,0,0, 32'h24090002, 32'hbfc00004);
        add(0, 32'hbfc00008, 6'd0, 0,1,0,32'h0,        1,1,0,0, 32'h24090002, 32'hbfc00004);
        add(0, 32'hbfc00008, 6'd0, 1,0,0,32'h0,        0,1,0,0, 32'h24090002, 32'hbfc00008);
        add(0, 32'h80000000, 6'd0, 0,0,0,32'h0,        0,1,0,0, 32'h24090002, 32'hbfc00008);
        add(0, 32'h80000000, 6'd0, 0,0,0,32'h0,        0,1,0,0, 32'h24090002, 32'hbfc00008);
        add(0, 32'h80000000, 6'd0, 0,0,1,32'h12345678, 0,1,0,0, 32'h24090002, 32'hbfc00008);
        add(0, 32'h80000000, 6'd0, 0,1,0,32'h0,        1,1,0,0, 32'h24090002, 32'hbfc00008);
        add(0, 32'h80000000, 6'd0, 0,0,1,32'h8c020000, 0,1,0,0, 32'h24090002, 32'h80000000);
        add(0, 32'h80000000, 6'd0, 0,0,0,32'h0,        0,0,1,0, 32'h8c020000, 32'h80000000);
        add(0, 32'hbfc00002, 6'd0, 0,1,0,32'h0,        0,1,0,0, 32'h8c020000, 32'h80000000);
        add(0, 32'hbfc00002, 6'b000010, 0,0,0,32'h0,   0,0,1,1, 32'h0,        32'hbfc00002);
        add(0, 32'hbfc00002, 6'd0, 0,0,0,32'h0,        0,0,1,1, 32'h0,        32'hbfc00002);
        add(0, 32'hbfc00010, 6'd0, 0,1,0,32'h0,        1,1,0,1, 32'h0,        32'hbfc00002);
        add(0, 32'hbfc00010, 6'd0, 1,0,1,32'hdeadbeef, 0,1,0,1, 32'h0,        32'hbfc00010);
        add(0, 32'hbfc00010, 6'd0, 0,0,0,32'h0,        1,1,0,1, 32'h0,        32'hbfc00010);
        add(0, 32'hbfc00010, 6'd0, 1,1,0,32'h0,        1,1,0,1, 32'h0,        32'hbfc00010);
        add(0, 32'hbfc00010, 6'd0, 0,0,0,32'h0,        0,1,0,1, 32'h0,        32'hbfc00010);
        add(0, 32'hbfc00010, 6'd0, 0,0,1,32'h11111111, 0,1,0,1, 32'h0,        32'hbfc00010);
        add(0, 32'hbfc00010, 6'd0, 0,1,0,32'h0,        1,1,0,1, 32'h0,        32'hbfc00010);
        add(0, 32'hbfc00010, 6'd0, 0,0,1,32'haaaa5555, 0,1,0,1, 32'h0,        32'hbfc00010);
        add(0, 32'hbfc00010, 6'b000010, 1,0,0,32'h0,   0,0,1,0, 32'haaaa5555, 32'hbfc00010);
        add(0, 32'hbfc00014, 6'd0, 0,1,0,32'h0,        1,1,0,0, 32'haaaa5555, 32'hbfc00010);
        add(1, 32'hbfc00014, 6'd0, 0,0,0,32'h0,        0,1,0,0, 32'haaaa5555, 32'hbfc00014);
        add(0, 32'hbfc00020, 6'd0, 0,0,0,32'h0,        0,1,0,0, 32'h0,        C_BOOT);
        add(0, 32'hbfc00020, 6'd0, 0,0,1,32'h99999999, 0,1,0,0, 32'h0,        C_BOOT);
        add(0, 32'hbfc00020, 6'd0, 0,1,0,32'h0,        1,1,0,0, 32'h0,        C_BOOT);
        add(0, 32'hbfc00020, 6'd0, 0,0,1,32'h01234567, 0,1,0,0, 32'h0,        32'hbfc00020);
        add(0, 32'hbfc00020, 6'd0, 0,0,0,32'h0,        0,0,1,0, 32'h01234567, 32'hbfc00020);
        add(0, 32'hbfc00024, 6'd0, 0,0,0,32'h0,        1,1,0,0, 32'h01234567, 32'hbfc00020);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].pc, vecs[i].stall, vecs[i].fl,
                  vecs[i].aok, vecs[i].dok, vecs[i].rd);
            #1;
            exp = {vecs[i].e_req, vecs[i].e_sreq, vecs[i].e_val, vecs[i].e_adel,
                   vecs[i].e_inst, vecs[i].e_pc};
            chk($sformatf("vec%0d", i), outs(), exp);
            chk($sformatf("vec%0d_addr", i), {36'h0, addr_when_req()},
                {36'h0, (vecs[i].e_req ? vecs[i].pc : 32'h0)});
            tick();
        end

        // Reset asserted while an instruction sits in HOLD under stall.
        drive(1'b0, 32'hbfc00030, 6'd0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'hbfc00030, 6'd0, 1'b0, 1'b0, 1'b1, 32'hcafef00d);
        tick();
        drive(1'b0, 32'hbfc00030, 6'b000010, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("hold_before_rst", outs(), {4'b0010, 32'hcafef00d, 32'hbfc00030});
        rst = 1'b1;
        tick();
        chk("rst_in_hold", outs(), {4'b0100, 32'h0, C_BOOT});
        rst = 1'b0;
        stall = 6'd0;
        #1;
        chk("req_after_rst", {67'h0, inst_req}, 68'h1);

        // Accepted fetches with varying return latency, bounded wait for delivery.
        for (int k = 0; k < 3; k++) begin
            addr = 32'h80001000 + 32'(k * 4);
            data = 32'h0badf000 + 32'(k);
            drive(1'b0, addr, 6'd0, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
            inst_addr_ok = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk($sformatf("lat%0d_wait", k), {66'h0, inst_req, stallreq_o}, 68'h1);
            end
            inst_data_ok = 1'b1;
            inst_rdata = data;
            tick();
            inst_data_ok = 1'b0;
            inst_rdata = 32'h0;
            got = 0;
            for (int c = 0; c < 10; c++) begin
                if (inst_valid_o) begin
                    got = 1;
                    break;
                end
                tick();
            end
            if (got == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL lat%0d_timeout: got no valid, expected valid within 10 cycles", k);
            end else begin
                chk($sformatf("lat%0d_data", k), outs(), {4'b0010, data, addr});
            end
            tick();
            chk($sformatf("lat%0d_after", k), {67'h0, inst_valid_o}, 68'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
